// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency/period meter.
package freq_meter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } pstate_t;

    // All-ones value of a w-bit counter, computed in 64 bits so w=64 still works.
    function automatic logic [63:0] sat_max(input int w);
        if (w >= 64)
            return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Measured signal in, measurement results out.
interface freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             sig_in;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             stale;

    modport master (
        input  sig_in,
        output count, count_valid, period, period_valid, stale
    );

    modport slave (
        output sig_in,
        input  count, count_valid, period, period_valid, stale
    );
endinterface

// File: rtl/freq_meter_sync_rise.sv
// Multi-flop synchronizer with a single-cycle rising-edge strobe.
module sync_rise #(
    parameter int SYNC_STAGES = 2
) (
    input  logic c1,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    // Everything resets high so an input held high through reset is not a rise.
    always_ff @(posedge c1 or posedge rst) begin
        if (rst) begin
            sync <= '1;
            hist <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/freq_meter.sv
// Gate-window edge counter plus edge-to-edge period meter for a slow async input.
//  state | meaning
//  IDLE  | no rising edge seen since reset; period unknown, stale
//  ARMED | at least one edge seen; pcnt counts cycles since the last edge
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          c1,
    input  logic          rst,
    freq_meter_if.master  bus
);
    localparam int               GW  = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);

    logic             rise;
    logic [GW-1:0]    gcnt;
    logic [CNT_W-1:0] ecnt;
    logic [CNT_W-1:0] pcnt;
    pstate_t          state;

    sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .c1   (c1),
        .rst  (rst),
        .d    (bus.sig_in),
        .rise (rise)
    );

    // A rise in the last gate cycle is folded into the closing window's count.
    always_ff @(posedge c1 or posedge rst) begin
        if (rst) begin
            gcnt            <= '0;
            ecnt            <= '0;
            bus.count       <= '0;
            bus.count_valid <= 1'b0;
        end else begin
            bus.count_valid <= 1'b0;
            if (gcnt == GATE_LAST) begin
                gcnt            <= '0;
                ecnt            <= '0;
                bus.count       <= (rise && ecnt != MAX) ? ecnt + 1'b1 : ecnt;
                bus.count_valid <= 1'b1;
            end else begin
                gcnt <= gcnt + 1'b1;
                if (rise && ecnt != MAX)
                    ecnt <= ecnt + 1'b1;
            end
        end
    end

    always_ff @(posedge c1 or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pcnt             <= '0;
            bus.period       <= '0;
            bus.period_valid <= 1'b0;
            bus.stale        <= 1'b1;
        end else begin
            bus.period_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= ARMED;
                        pcnt      <= CNT_W'(1);
                        bus.stale <= 1'b0;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        bus.period       <= pcnt;
                        bus.period_valid <= 1'b1;
                        pcnt             <= CNT_W'(1);
                        bus.stale        <= 1'b0;
                    end else if (pcnt != MAX) begin
                        pcnt      <= pcnt + 1'b1;
                        bus.stale <= (pcnt == MAX - 1'b1);
                    end else begin
                        bus.stale <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with GATE_CYCLES=100, CNT_W=8, SYNC_STAGES=2.
module tb_freq_meter;
    logic c1 = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   c;
    int   nwin;

    freq_meter_if #(.CNT_W(8)) bus ();

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .c1  (c1),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 c1 = ~c1;

    task automatic do_reset(input logic lvl);
        rst = 1'b1;
        bus.sig_in = lvl;
        repeat (3) @(posedge c1);
        @(negedge c1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sig_in = 1'b1;
        repeat (3) @(posedge c1);
        #1;
        total++;
        if (bus.count !== 8'd0 || bus.period !== 8'd0 || bus.count_valid !== 1'b0 ||
            bus.period_valid !== 1'b0 || bus.stale !== 1'b1) begin
            bad++;
            $display("FAIL reset_values: count=%0d period=%0d cv=%b pv=%b stale=%b want 0 0 0 0 1",
                     bus.count, bus.period, bus.count_valid, bus.period_valid, bus.stale);
        end
        @(negedge c1);
        rst = 1'b0;
        for (int i = 0; i < 105; i++) begin
            @(posedge c1); #1;
            c = i + 1;
            total++;
            if (bus.period_valid !== 1'b0 || bus.stale !== 1'b1) begin
                bad++;
                $display("FAIL held_high cyc=%0d: pv=%b stale=%b want pv=0 stale=1",
                         c, bus.period_valid, bus.stale);
            end
            total++;
            if (bus.count_valid !== (c == 100)) begin
                bad++;
                $display("FAIL first_cv cyc=%0d: cv=%b want %b", c, bus.count_valid, c == 100);
            end
            if (c == 100) begin
                total++;
                if (bus.count !== 8'd0) begin
                    bad++;
                    $display("FAIL first_count: got %0d want 0", bus.count);
                end
            end
        end
    endtask

    // High for i%10 in 5..9: rises land at cycles 8,18,...,298.
    task automatic test_square10();
        do_reset(1'b0);
        nwin = 0;
        for (int i = 0; i < 300; i++) begin
            bus.sig_in = ((i % 10) >= 5);
            @(posedge c1); #1;
            c = i + 1;
            total++;
            if (bus.count_valid !== ((c % 100) == 0)) begin
                bad++;
                $display("FAIL sq10_cv cyc=%0d: cv=%b", c, bus.count_valid);
            end
            if (bus.count_valid === 1'b1) begin
                nwin++;
                total++;
                if (bus.count !== 8'd10) begin
                    bad++;
                    $display("FAIL sq10_count cyc=%0d: got %0d want 10", c, bus.count);
                end
            end
            total++;
            if (bus.period_valid !== (c >= 18 && (c % 10) == 8)) begin
                bad++;
                $display("FAIL sq10_pv cyc=%0d: pv=%b", c, bus.period_valid);
            end
            if (bus.period_valid === 1'b1) begin
                total++;
                if (bus.period !== 8'd10) begin
                    bad++;
                    $display("FAIL sq10_period cyc=%0d: got %0d want 10", c, bus.period);
                end
            end
            if (c == 2 || c == 23) begin
                total++;
                if (bus.stale !== (c == 2)) begin
                    bad++;
                    $display("FAIL sq10_stale cyc=%0d: got %b want %b", c, bus.stale, c == 2);
                end
            end
        end
        total++;
        if (nwin != 3) begin
            bad++;
            $display("FAIL sq10_windows: got %0d want 3", nwin);
        end
    endtask

    // Rises land at cycles 13, 100 (last gate cycle) and 163.
    task automatic test_gate_boundary();
        do_reset(1'b0);
        for (int i = 0; i < 205; i++) begin
            bus.sig_in = (i >= 10 && i <= 14) || (i >= 97 && i <= 150) || (i >= 160 && i <= 170);
            @(posedge c1); #1;
            c = i + 1;
            total++;
            if (bus.count_valid !== (c == 100 || c == 200)) begin
                bad++;
                $display("FAIL gate_cv cyc=%0d: cv=%b", c, bus.count_valid);
            end
            if (c == 100 || c == 200) begin
                total++;
                if (bus.count !== ((c == 100) ? 8'd2 : 8'd1)) begin
                    bad++;
                    $display("FAIL gate_count cyc=%0d: got %0d want %0d", c, bus.count,
                             (c == 100) ? 2 : 1);
                end
            end
            total++;
            if (bus.period_valid !== (c == 100 || c == 163)) begin
                bad++;
                $display("FAIL gate_pv cyc=%0d: pv=%b", c, bus.period_valid);
            end
            if (c == 100 || c == 163) begin
                total++;
                if (bus.period !== ((c == 100) ? 8'd87 : 8'd63)) begin
                    bad++;
                    $display("FAIL gate_period cyc=%0d: got %0d want %0d", c, bus.period,
                             (c == 100) ? 87 : 63);
                end
            end
        end
    endtask

    // Toggle every cycle: rises on every even cycle from 4.
    task automatic test_fast();
        do_reset(1'b0);
        nwin = 0;
        for (int i = 0; i < 300; i++) begin
            bus.sig_in = (i % 2) == 1;
            @(posedge c1); #1;
            c = i + 1;
            if (bus.count_valid === 1'b1) begin
                nwin++;
                total++;
                if (bus.count !== ((nwin == 1) ? 8'd49 : 8'd50)) begin
                    bad++;
                    $display("FAIL fast_count win=%0d: got %0d want %0d", nwin, bus.count,
                             (nwin == 1) ? 49 : 50);
                end
            end
            if (bus.period_valid === 1'b1) begin
                total++;
                if (bus.period !== 8'd2) begin
                    bad++;
                    $display("FAIL fast_period cyc=%0d: got %0d want 2", c, bus.period);
                end
            end
            if (c == 150) begin
                total++;
                if (bus.stale !== 1'b0) begin
                    bad++;
                    $display("FAIL fast_stale: got %b want 0", bus.stale);
                end
            end
        end
        total++;
        if (nwin != 3) begin
            bad++;
            $display("FAIL fast_windows: got %0d want 3", nwin);
        end
    endtask

    // Rise at cycle 4, then none until cycle 307.
    task automatic test_stale_gap();
        do_reset(1'b0);
        for (int i = 0; i < 310; i++) begin
            bus.sig_in = (i >= 1 && i <= 5) || (i >= 304);
            @(posedge c1); #1;
            c = i + 1;
            if (c == 257 || c == 258 || c == 306 || c == 307) begin
                total++;
                if (bus.stale !== (c == 258 || c == 306)) begin
                    bad++;
                    $display("FAIL gap_stale cyc=%0d: got %b want %b", c, bus.stale,
                             c == 258 || c == 306);
                end
            end
            total++;
            if (bus.period_valid !== (c == 307)) begin
                bad++;
                $display("FAIL gap_pv cyc=%0d: pv=%b", c, bus.period_valid);
            end
            if (c == 307) begin
                total++;
                if (bus.period !== 8'd255) begin
                    bad++;
                    $display("FAIL gap_period: got %0d want 255", bus.period);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        for (int i = 0; i < 140; i++) begin
            bus.sig_in = ((i % 10) >= 5);
            @(posedge c1); #1;
        end
        total++;
        if (bus.count !== 8'd10 || bus.period !== 8'd10 || bus.stale !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset: count=%0d period=%0d stale=%b want 10 10 0",
                     bus.count, bus.period, bus.stale);
        end
        rst = 1'b1;
        bus.sig_in = 1'b0;
        #1;
        total++;
        if (bus.count !== 8'd0 || bus.period !== 8'd0 || bus.count_valid !== 1'b0 ||
            bus.period_valid !== 1'b0 || bus.stale !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: count=%0d period=%0d cv=%b pv=%b stale=%b want 0 0 0 0 1",
                     bus.count, bus.period, bus.count_valid, bus.period_valid, bus.stale);
        end
        repeat (2) @(posedge c1);
        @(negedge c1);
        rst = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge c1); #1;
            c = i + 1;
            total++;
            if (bus.count_valid !== (c == 100)) begin
                bad++;
                $display("FAIL post_reset_cv cyc=%0d: cv=%b want %b", c, bus.count_valid, c == 100);
            end
            if (c == 100) begin
                total++;
                if (bus.count !== 8'd0) begin
                    bad++;
                    $display("FAIL post_reset_count: got %0d want 0", bus.count);
                end
            end
        end
    endtask

    initial begin
        bus.sig_in = 1'b1;
        test_reset();
        test_square10();
        test_gate_boundary();
        test_fast();
        test_stale_gap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, total=%0d", total);
        $fatal(1);
    end
endmodule
